// File: rtl/rv_alu_pkg.sv
// Shared opcode, ALU control and branch condition encodings for the RV32I ALU.
package rv_alu_pkg;

  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;

  // ALU control codes are {funct7[5], funct3}
  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_SLL  = 4'b0001;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SRA  = 4'b1101;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // funct3 value that keeps funct7[5] meaningful for immediate ops (SRLI/SRAI)
  localparam logic [2:0] F3_SHIFT_RIGHT = 3'b101;

endpackage

// File: rtl/rv_alu_branch_cmp.sv
// Combinational branch comparator: decides whether a conditional branch is taken.
module rv_alu_branch_cmp
  import rv_alu_pkg::*;
(
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic [2:0]  funct3,
  output logic        taken
);

  logic eq;
  logic lt_signed;
  logic lt_unsigned;

  assign eq          = (src_a == src_b);
  assign lt_signed   = ($signed(src_a) < $signed(src_b));
  assign lt_unsigned = (src_a < src_b);

  // Select the comparison named by funct3; reserved encodings never branch
  always_comb begin
    taken = 1'b0;
    case (funct3)
      F3_BEQ:  taken = eq;
      F3_BNE:  taken = ~eq;
      F3_BLT:  taken = lt_signed;
      F3_BGE:  taken = ~lt_signed;
      F3_BLTU: taken = lt_unsigned;
      F3_BGEU: taken = ~lt_unsigned;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/rv_alu.sv
// RV32I execute-stage ALU with registered result and branch/jump taken flag.
module rv_alu
  import rv_alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [6:0]      opcode_reg,
  input  logic [3:0]      ALUControl_reg,
  input  logic [XLEN-1:0] SrcA,
  input  logic [XLEN-1:0] SrcB,
  output logic [XLEN-1:0] ALUResult,
  output logic            Cond_Chk
);

  logic [XLEN-1:0] sum;
  logic [XLEN-1:0] diff;
  logic [4:0]      shamt;
  logic [3:0]      alu_code;
  logic [XLEN-1:0] alu_out;
  logic            branch_taken;
  logic [XLEN-1:0] result_next;
  logic            cond_next;

  assign sum   = SrcA + SrcB;
  assign diff  = SrcA - SrcB;
  assign shamt = SrcB[4:0];

  rv_alu_branch_cmp u_branch_cmp (
    .src_a  (SrcA),
    .src_b  (SrcB),
    .funct3 (ALUControl_reg[2:0]),
    .taken  (branch_taken)
  );

  // Immediate ops only honour funct7[5] for right shifts, so mask it elsewhere
  always_comb begin
    alu_code = ALUControl_reg;
    if (opcode_reg == OP_IMM && ALUControl_reg[2:0] != F3_SHIFT_RIGHT)
      alu_code = {1'b0, ALUControl_reg[2:0]};
  end

  // Arithmetic/logic table shared by register and immediate forms
  always_comb begin
    alu_out = '0;
    case (alu_code)
      ALU_ADD:  alu_out = sum;
      ALU_SUB:  alu_out = diff;
      ALU_SLL:  alu_out = SrcA << shamt;
      ALU_SLT:  alu_out = {{(XLEN-1){1'b0}}, $signed(SrcA) < $signed(SrcB)};
      ALU_SLTU: alu_out = {{(XLEN-1){1'b0}}, SrcA < SrcB};
      ALU_XOR:  alu_out = SrcA ^ SrcB;
      ALU_SRL:  alu_out = SrcA >> shamt;
      ALU_SRA:  alu_out = $unsigned($signed(SrcA) >>> shamt);
      ALU_OR:   alu_out = SrcA | SrcB;
      ALU_AND:  alu_out = SrcA & SrcB;
      default:  alu_out = '0;
    endcase
  end

  // Opcode-level result mux and taken flag
  always_comb begin
    result_next = '0;
    cond_next   = 1'b0;
    case (opcode_reg)
      OP, OP_IMM: result_next = alu_out;
      BRANCH: begin
        result_next = diff;
        cond_next   = branch_taken;
      end
      JAL, JALR: begin
        result_next = sum;
        cond_next   = 1'b1;
      end
      LOAD, STORE, AUIPC: result_next = sum;
      LUI:                result_next = SrcB;
      default: begin
        result_next = '0;
        cond_next   = 1'b0;
      end
    endcase
  end

  // Output registers, cleared immediately by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ALUResult <= '0;
      Cond_Chk  <= 1'b0;
    end else begin
      ALUResult <= result_next;
      Cond_Chk  <= cond_next;
    end
  end

endmodule

// File: tb/tb_rv_alu.sv
// Directed self-checking bench for rv_alu with hand-computed expected values.
module tb_rv_alu;
  import rv_alu_pkg::*;

  logic        clk;
  logic        rst;
  logic [6:0]  opcode_reg;
  logic [3:0]  ALUControl_reg;
  logic [31:0] SrcA;
  logic [31:0] SrcB;
  logic [31:0] ALUResult;
  logic        Cond_Chk;

  int checkCount;
  int failCount;

  rv_alu dut (
    .clk            (clk),
    .rst            (rst),
    .opcode_reg     (opcode_reg),
    .ALUControl_reg (ALUControl_reg),
    .SrcA           (SrcA),
    .SrcB           (SrcB),
    .ALUResult      (ALUResult),
    .Cond_Chk       (Cond_Chk)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value with its expected value and tally the result
  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
    end
  endtask

  // Drive one operation on the falling edge, then let one rising edge register it
  task automatic applyStimulus(input logic [6:0] op, input logic [3:0] ctrl,
                               input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    opcode_reg     = op;
    ALUControl_reg = ctrl;
    SrcA           = a;
    SrcB           = b;
    @(posedge clk);
    #1;
  endtask

  // Apply an operation and check both outputs one cycle later
  task automatic runCase(input string tag, input logic [6:0] op, input logic [3:0] ctrl,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] expResult, input logic expCond);
    applyStimulus(op, ctrl, a, b);
    checkOutput({tag, "_res"}, ALUResult, expResult);
    checkOutput({tag, "_cond"}, {31'd0, Cond_Chk}, {31'd0, expCond});
  endtask

  initial begin
    checkCount     = 0;
    failCount      = 0;
    rst            = 1'b1;
    opcode_reg     = OP;
    ALUControl_reg = ALU_ADD;
    SrcA           = 32'd5;
    SrcB           = 32'd6;
    #1;
    checkOutput("reset_res", ALUResult, 32'd0);
    checkOutput("reset_cond", {31'd0, Cond_Chk}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    runCase("add",  OP, ALU_ADD, 32'd5, 32'd6, 32'd11, 1'b0);
    runCase("jal_pre", JAL, 4'b0000, 32'd1, 32'd2, 32'd3, 1'b1);

    // Reset asserted mid-run must clear outputs before any clock edge
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("midrst_res", ALUResult, 32'd0);
    checkOutput("midrst_cond", {31'd0, Cond_Chk}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    runCase("add_after_rst", OP, ALU_ADD, 32'd5, 32'd6, 32'd11, 1'b0);

    runCase("sub",  OP, ALU_SUB, 32'd567, 32'd6, 32'd561, 1'b0);
    runCase("sub_wrap", OP, ALU_SUB, 32'd0, 32'd1, 32'hFFFF_FFFF, 1'b0);
    runCase("add_wrap", OP, ALU_ADD, 32'hFFFF_FFFF, 32'd2, 32'd1, 1'b0);
    runCase("or",   OP, ALU_OR,  32'd5, 32'd6, 32'd7, 1'b0);
    runCase("and",  OP, ALU_AND, 32'd5, 32'd6, 32'd4, 1'b0);
    runCase("xor",  OP, ALU_XOR, 32'd5, 32'd6, 32'd3, 1'b0);
    runCase("addi_1000", OP_IMM, 4'b1000, 32'd5, 32'd7, 32'd12, 1'b0);

    runCase("srl8", OP, ALU_SRL, 32'h8765_4321, 32'd8, 32'h0087_6543, 1'b0);
    runCase("sra8", OP, ALU_SRA, 32'h8765_4321, 32'd8, 32'hFF87_6543, 1'b0);
    runCase("sll8", OP, ALU_SLL, 32'h1234_5678, 32'd8, 32'h3456_7800, 1'b0);
    runCase("srl31", OP, ALU_SRL, 32'h8000_0000, 32'd31, 32'd1, 1'b0);
    runCase("sra31", OP, ALU_SRA, 32'h8000_0000, 32'd31, 32'hFFFF_FFFF, 1'b0);
    runCase("sll31", OP, ALU_SLL, 32'd1, 32'd31, 32'h8000_0000, 1'b0);
    runCase("srl0",  OP, ALU_SRL, 32'h8765_4321, 32'd0, 32'h8765_4321, 1'b0);
    runCase("sll_b5", OP, ALU_SLL, 32'd1, 32'd33, 32'd2, 1'b0);
    runCase("srai", OP_IMM, 4'b1101, 32'h8000_0000, 32'd4, 32'hF800_0000, 1'b0);
    runCase("srli", OP_IMM, 4'b0101, 32'h8000_0000, 32'd4, 32'h0800_0000, 1'b0);

    runCase("slt_pos",  OP, ALU_SLT,  32'h1234_5678, 32'h0000_FFFF, 32'd0, 1'b0);
    runCase("sltu_pos", OP, ALU_SLTU, 32'h1234_5678, 32'h0000_FFFF, 32'd0, 1'b0);
    runCase("slt_neg",  OP, ALU_SLT,  32'h8000_0000, 32'd1, 32'd1, 1'b0);
    runCase("sltu_neg", OP, ALU_SLTU, 32'h8000_0000, 32'd1, 32'd0, 1'b0);
    runCase("slt_ext",  OP, ALU_SLT,  32'h8000_0000, 32'h7FFF_FFFF, 32'd1, 1'b0);
    runCase("sltu_ext", OP, ALU_SLTU, 32'h8000_0000, 32'h7FFF_FFFF, 32'd0, 1'b0);
    runCase("slti_1010", OP_IMM, 4'b1010, 32'h8000_0000, 32'd1, 32'd1, 1'b0);
    runCase("op_unlisted", OP, 4'b1010, 32'h8000_0000, 32'd1, 32'd0, 1'b0);

    runCase("beq_ne", BRANCH, {1'b0, F3_BEQ}, 32'd8, 32'd87, 32'hFFFF_FFB1, 1'b0);
    runCase("beq_eq", BRANCH, {1'b0, F3_BEQ}, 32'd87, 32'd87, 32'd0, 1'b1);
    runCase("beq_b3", BRANCH, {1'b1, F3_BEQ}, 32'd87, 32'd87, 32'd0, 1'b1);
    runCase("bne", BRANCH, {1'b0, F3_BNE}, 32'd1, 32'd2, 32'hFFFF_FFFF, 1'b1);
    runCase("blt_no",  BRANCH, {1'b0, F3_BLT}, 32'd908, 32'd87, 32'd821, 1'b0);
    runCase("blt_yes", BRANCH, {1'b0, F3_BLT}, 32'd8, 32'd87, 32'hFFFF_FFB1, 1'b1);
    runCase("blt_ext", BRANCH, {1'b0, F3_BLT}, 32'h8000_0000, 32'h7FFF_FFFF, 32'd1, 1'b1);
    runCase("bltu_ext", BRANCH, {1'b0, F3_BLTU}, 32'h8000_0000, 32'h7FFF_FFFF, 32'd1, 1'b0);
    runCase("bge_neg", BRANCH, {1'b0, F3_BGE}, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFE, 1'b0);
    runCase("bgeu", BRANCH, {1'b0, F3_BGEU}, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFE, 1'b1);
    runCase("b_f3_010", BRANCH, 4'b0010, 32'd5, 32'd5, 32'd0, 1'b0);

    runCase("jal", JAL, 4'b1111, 32'h1234_5678, 32'h0000_FFFF, 32'h1235_5677, 1'b1);
    runCase("jalr", JALR, 4'b0000, 32'd100, 32'hFFFF_FFFC, 32'd96, 1'b1);
    runCase("load", LOAD, 4'b0010, 32'd100, 32'd4, 32'd104, 1'b0);
    runCase("store", STORE, 4'b0000, 32'd200, 32'd8, 32'd208, 1'b0);
    runCase("auipc", AUIPC, 4'b0000, 32'h0000_1000, 32'h0002_0000, 32'h0002_1000, 1'b0);
    runCase("lui", LUI, 4'b0000, 32'h1111_1111, 32'hABCD_E000, 32'hABCD_E000, 1'b0);
    runCase("undef", 7'h7F, 4'b0000, 32'd5, 32'd6, 32'd0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
